// File: rtl/dig_decode.sv
// Registered hex-to-seven-segment decoder: one nibble in, segments {g,f,e,d,c,b,a} out
// one cycle later, with selectable cathode polarity.
module dig_decode #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] x,
    output logic [6:0] dig
);

    localparam logic [6:0] BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [6:0] seg_on;
    logic [6:0] dig_d;
    logic [6:0] dig_q;

    // Lit-set per value, 1 = segment on. Unknown inputs fall to default (blank).
    always_comb begin
        seg_on = 7'h00;
        case (x)
            4'h0: seg_on = 7'h3F;
            4'h1: seg_on = 7'h06;
            4'h2: seg_on = 7'h5B;
            4'h3: seg_on = 7'h4F;
            4'h4: seg_on = 7'h66;
            4'h5: seg_on = 7'h6D;
            4'h6: seg_on = 7'h7D;
            4'h7: seg_on = 7'h07;
            4'h8: seg_on = 7'h7F;
            4'h9: seg_on = 7'h6F;
            4'hA: seg_on = 7'h77;
            4'hB: seg_on = 7'h7C;
            4'hC: seg_on = 7'h39;
            4'hD: seg_on = 7'h5E;
            4'hE: seg_on = 7'h79;
            4'hF: seg_on = 7'h71;
            default: seg_on = 7'h00;
        endcase
    end

    assign dig_d = ACTIVE_LOW ? ~seg_on : seg_on;

    always_ff @(posedge clk) begin
        if (reset) dig_q <= BLANK;
        else       dig_q <= dig_d;
    end

    assign dig = dig_q;

endmodule

// File: tb/tb_dig_decode.sv
// Directed bench for dig_decode; both polarities run side by side on shared stimulus.
module tb_dig_decode;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] x = 4'h0;
    logic [6:0] dig_al;
    logic [6:0] dig_ah;

    int n_vec = 0;
    int n_err = 0;

    logic [6:0] exp_al [16];
    logic [6:0] exp_ah [16];

    always #5 clk = ~clk;

    dig_decode #(.ACTIVE_LOW(1'b1)) u_al (.clk(clk), .reset(reset), .x(x), .dig(dig_al));
    dig_decode #(.ACTIVE_LOW(1'b0)) u_ah (.clk(clk), .reset(reset), .x(x), .dig(dig_ah));

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, want 0x%02h", tag, obs, expv);
        end
    endtask

    // Drive inputs 1 time unit after an edge, then sample 1 unit after the following edge.
    task automatic apply(input logic [3:0] xv, input logic rv);
        x = xv;
        reset = rv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_al = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        exp_ah = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

        @(negedge clk);
        // Reset held with x=8
        for (int i = 0; i < 2; i++) begin
            apply(4'h8, 1'b1);
            chk("rst_al", dig_al, 7'h7F);
            chk("rst_ah", dig_ah, 7'h00);
        end
        apply(4'h8, 1'b0);
        chk("rel_al", dig_al, 7'h00);
        chk("rel_ah", dig_ah, 7'h7F);

        // Exhaustive sweep, both polarities
        for (int v = 0; v < 16; v++) begin
            apply(v[3:0], 1'b0);
            chk($sformatf("sweep_al_%0h", v), dig_al, exp_al[v]);
            chk($sformatf("sweep_ah_%0h", v), dig_ah, exp_ah[v]);
        end
        // Wrap F -> 0
        apply(4'h0, 1'b0);
        chk("wrap_al", dig_al, 7'h40);
        chk("wrap_ah", dig_ah, 7'h3F);

        // Reset mid-stream on the x=4 cycle
        apply(4'h3, 1'b0);
        chk("mid3", dig_al, 7'h30);
        apply(4'h4, 1'b1);
        chk("mid4_rst", dig_al, 7'h7F);
        chk("mid4_rst_ah", dig_ah, 7'h00);
        apply(4'h5, 1'b0);
        chk("mid5", dig_al, 7'h12);

        // Reset raised between edges must not affect dig until the next edge
        reset = 1'b1;
        #2;
        chk("sync_hold", dig_al, 7'h12);
        chk("sync_hold_ah", dig_ah, 7'h6D);
        apply(4'h5, 1'b1);
        chk("sync_edge", dig_al, 7'h7F);
        apply(4'h5, 1'b0);
        chk("sync_rel", dig_al, 7'h12);

        // Scanner rotation 1,2,3,4
        for (int i = 0; i < 8; i++) begin
            logic [3:0] sv;
            sv = 4'((i % 4) + 1);
            apply(sv, 1'b0);
            chk($sformatf("scan_%0d", i), dig_al, exp_al[sv]);
        end

        // Hold x=A
        for (int i = 0; i < 10; i++) begin
            apply(4'hA, 1'b0);
            chk($sformatf("hold_%0d", i), dig_al, 7'h08);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
